// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: multiply/divide op codes, R-type funct values
// and the mult_div_unit state type.
package mips_pkg;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    localparam logic [5:0] MFHI  = 6'h10;
    localparam logic [5:0] MTHI  = 6'h11;
    localparam logic [5:0] MFLO  = 6'h12;
    localparam logic [5:0] MTLO  = 6'h13;
    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1A;
    localparam logic [5:0] DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/mult_div_unit_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or
// restoring shift-subtract divide over a 2*WIDTH+1 bit accumulator.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH:0]   acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH:0]   acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, opnd};
        acc_next = {1'b0, sum, acc[WIDTH-1:1]};
        // Divide: remainder lives in the upper half, quotient bits shift in at the bottom
        if (is_div) begin
            if (rem_sh >= {1'b0, opnd})
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {rem_sh, acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: sign-magnitude front end, WIDTH radix-2 steps,
// then a sign-fix cycle that commits HI/LO and pulses done.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_t        state;
    logic [CW-1:0]    count;
    logic [1:0]       op_r;
    logic             rs_neg, rt_neg, rt_zero;
    logic [WIDTH-1:0] opnd;
    logic [2*WIDTH:0] acc, acc_step;
    logic             signed_in, div_in, div_r;
    logic [WIDTH-1:0] rs_mag, rt_mag;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic sgn);
        return (sgn && v < 0) ? WIDTH'(-v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] sign_fix_wide(input logic [2*WIDTH-1:0] v,
                                                         input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign signed_in = (op == MD_MULT) || (op == MD_DIV);
    assign div_in    = (op == MD_DIV)  || (op == MD_DIVU);
    assign div_r     = (op_r == MD_DIV) || (op_r == MD_DIVU);
    assign rs_mag    = magnitude(rs_val, signed_in);
    assign rt_mag    = magnitude(rt_val, signed_in);

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (div_r),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_step)
    );

    // Operand capture and iteration datapath
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            op_r    <= op;
            rs_neg  <= signed_in && rs_val[WIDTH-1];
            rt_neg  <= signed_in && rt_val[WIDTH-1];
            rt_zero <= (rt_val == '0);
            opnd    <= div_in ? rt_mag : rs_mag;
            acc     <= {{(WIDTH+1){1'b0}}, (div_in ? rs_mag : rt_mag)};
        end else if (state == CALC) begin
            acc <= acc_step;
        end
    end

    // Control FSM and architectural HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi) hi <= rs_val;
                    if (mtlo) lo <= rs_val;
                    if (start) begin
                        state <= CALC;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (div_r) begin
                        // Remainder keeps the dividend sign, which also restores rs for /0
                        hi          <= sign_fix(acc[2*WIDTH-1:WIDTH], rs_neg);
                        lo          <= rt_zero ? {WIDTH{1'b1}}
                                               : sign_fix(acc[WIDTH-1:0], rs_neg ^ rt_neg);
                        div_by_zero <= rt_zero;
                    end else begin
                        {hi, lo} <= sign_fix_wide(acc[2*WIDTH-1:0], rs_neg ^ rt_neg);
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    count <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed and random ops checked against
// a plain-arithmetic HI/LO model, with latency and done-count checks.
module tb_mult_div_unit;
    import mips_pkg::*;

    localparam int W = 32;

    logic          clk = 0;
    logic          rst = 1;
    logic          start = 0;
    logic [1:0]    op = 0;
    logic [W-1:0]  rs_val = 0, rt_val = 0;
    logic          mthi = 0, mtlo = 0;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0, n_err = 0;
    int          cyc = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    logic        m_dbz = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic dz_in, output logic [31:0] rh, output logic [31:0] rl,
                         output logic dz);
        longint          sp;
        longint unsigned up, ua, ub;
        int              sa, sb;
        dz = dz_in;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            MD_MULT: begin
                sp = longint'(sa) * longint'(sb);
                {rh, rl} = sp;
            end
            MD_MULTU: begin
                ua = {32'd0, a};
                ub = {32'd0, b};
                up = ua * ub;
                {rh, rl} = up;
            end
            MD_DIV: begin
                dz = (b == 0);
                if (b == 0) begin
                    rl = 32'hFFFF_FFFF; rh = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    rl = 32'h8000_0000; rh = 0;
                end else begin
                    rl = sa / sb; rh = sa % sb;
                end
            end
            default: begin
                dz = (b == 0);
                if (b == 0) begin
                    rl = 32'hFFFF_FFFF; rh = a;
                end else begin
                    rl = a / b; rh = a % b;
                end
            end
        endcase
    endtask

    // Monitor: every done pulse must match the oldest outstanding operation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no completion", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("result_hi", hi, e.hi);
                check("result_lo", lo, e.lo);
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                check("done_cycle", cyc, e.cyc);
                check("busy_after_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Presents one start (optionally with a move) at the next edge; returns after that edge
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic mh, input logic ml, input bit push);
        int          t;
        exp_t        e;
        logic [31:0] rh, rl;
        logic        dz;
        t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            n_cmp++; n_err++;
            $display("FAIL wait_idle: got busy=1 after %0d cycles expected 0", t);
        end
        op = o; rs_val = a; rt_val = b; mthi = mh; mtlo = ml; start = 1;
        if (mh) m_hi = a;
        if (ml) m_lo = a;
        model(o, a, b, m_dbz, rh, rl, dz);
        if (push) begin
            e.hi = rh; e.lo = rl; e.dbz = dz; e.cyc = cyc + 1 + W + 1;
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 0; mthi = 0; mtlo = 0;
        if (mh) check("move_with_start_hi", hi, a);
        if (ml) check("move_with_start_lo", lo, a);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        if (push) begin
            m_hi = rh; m_lo = rl; m_dbz = dz;
        end
    endtask

    task automatic finish_op();
        int t;
        t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            n_cmp++; n_err++;
            $display("FAIL op_timeout: got busy=1 after %0d cycles expected 0", t);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        launch(o, a, b, 0, 0, 1);
        finish_op();
    endtask

    task automatic move(input logic [31:0] a, input logic mh, input logic ml);
        rs_val = a; mthi = mh; mtlo = ml;
        if (mh) m_hi = a;
        if (ml) m_lo = a;
        @(negedge clk);
        mthi = 0; mtlo = 0;
        check("move_hi", hi, m_hi);
        check("move_lo", lo, m_lo);
    endtask

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ohi, olo;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst = 0;
        @(negedge clk);

        move(32'h0000_1234, 1, 0);
        move(32'h0000_5678, 0, 1);
        move(32'h0000_9ABC, 1, 1);

        issue(MD_MULT, 32'd7, 32'hFFFF_FFFD);
        check("t1_hi", hi, 32'hFFFF_FFFF);
        check("t1_lo", lo, 32'hFFFF_FFEB);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("t2_hi", hi, 32'hFFFF_FFFE);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        check("t3_lo", lo, 32'hFFFF_FFFD);
        issue(MD_DIVU, 32'h100, 32'd7);
        check("t3u_lo", lo, 32'h24);
        issue(MD_DIVU, 32'h64, 32'd0);
        check("t4_dbz", {31'd0, div_by_zero}, 32'd1);
        issue(MD_MULT, 32'd9, 32'd9);
        check("dbz_sticky_over_mult", {31'd0, div_by_zero}, 32'd1);
        issue(MD_DIV, 32'd6, 32'd3);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(MD_DIV, 32'h8000_0001, 32'd0);

        // Requests while busy are dropped; HI/LO hold their old values
        ohi = m_hi; olo = m_lo;
        launch(MD_MULT, 32'd3, 32'd5, 0, 0, 1);
        repeat (9) @(negedge clk);
        op = MD_DIV; rs_val = 32'hAA; rt_val = 32'd1; start = 1; mthi = 1;
        @(negedge clk);
        start = 0; mthi = 0;
        check("busy_hold_hi", hi, ohi);
        check("busy_hold_lo", lo, olo);
        finish_op();
        check("t5_lo", lo, 32'hF);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-operation
        launch(MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0);
        repeat (11) @(negedge clk);
        @(posedge clk);
        #2 rst = 1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        m_hi = 0; m_lo = 0; m_dbz = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        issue(MD_MULT, 32'd2, 32'd2);
        check("t6_lo", lo, 32'd4);

        launch(MD_DIVU, 32'd50, 32'd7, 1, 1, 1);
        finish_op();

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            logic        rmh, rml;
            ro  = 2'($urandom_range(0, 3));
            ra  = pick($urandom_range(0, 7));
            rb  = pick($urandom_range(0, 7));
            rmh = ($urandom_range(0, 7) == 0);
            rml = ($urandom_range(0, 7) == 0);
            launch(ro, ra, rb, rmh, rml, 1);
            finish_op();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("pending_results", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by %0t expected finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
